wb_buffer: RTL
==============

WB_BUFFER -- requirements
Module: wb_buffer

Interface
REQ-001 Parameter: DEPTH, 4, number of pending-write entries; power of two, 2..16.
REQ-002 Parameter: WORD_LEN, 32, data width; REG_IDX_WIDTH, 5, register index width.
REQ-003 Port: clk  in  1  single clock; all state updates on rising edge.
REQ-004 Port: reset  in  1  synchronous, active-high reset, sampled on rising edge of clk.
REQ-005 Port: inValid  in  1  producer offers a result this cycle.
REQ-006 Port: inReady  out  1  buffer accepts the offer this cycle.
REQ-007 Port: inAddr  in  REG_IDX_WIDTH  destination register of offered result.
REQ-008 Port: inData  in  WORD_LEN  offered result value.
REQ-009 Port: hold  in  1  suppresses draining to the register file while high.
REQ-010 Port: writeEnable  out  1  register-file write strobe for the head entry.
REQ-011 Port: writeAddr  out  REG_IDX_WIDTH  head entry destination.
REQ-012 Port: writeData  out  WORD_LEN  head entry value.
REQ-013 Port: fwdAddr1, fwdAddr2  in  REG_IDX_WIDTH each  register indices being read by decode.
REQ-014 Port: fwdHit1, fwdHit2  out  1 each  a pending entry targets the matching fwdAddr.
REQ-015 Port: fwdData1, fwdData2  out  WORD_LEN each  value of youngest matching pending entry.
REQ-016 Port: count  out  clog2(DEPTH)+1  number of valid entries.

Function
REQ-017 Storage is a circular FIFO of DEPTH entries {addr, data}, with head/tail pointers wrapping modulo DEPTH and a separate count.
REQ-018 inReady = (count < DEPTH); combinational from count only, never from inValid or hold.
REQ-019 Accept = inValid && inReady; on accept with inAddr != 0, entry written at tail, tail advances.
REQ-020 On accept with inAddr == 0, handshake completes but nothing is enqueued; count, tail unchanged.
REQ-021 writeEnable = (count != 0) && !hold; writeAddr/writeData = head entry, combinational.
REQ-022 writeAddr/writeData drive 0 when count == 0.
REQ-023 Drain = writeEnable; on drain, head advances at the rising edge ending the cycle (downstream commits on the preceding falling edge).
REQ-024 Latency: an entry accepted into an empty buffer with hold low produces writeEnable in the next cycle, exactly one cycle wide.
REQ-025 Simultaneous accept (non-zero addr) and drain: count unchanged, both pointers advance.
REQ-026 When full, accept is refused even if drain occurs the same cycle; inReady rises the cycle after count drops.
REQ-027 Entries drain strictly in acceptance order; one entry per cycle maximum.
REQ-028 fwdHitN = 1 iff fwdAddrN != 0 and some valid entry (head included) has addr == fwdAddrN.
REQ-029 fwdDataN = data of the youngest (most recently accepted) matching entry; 0 when fwdHitN = 0.
REQ-030 Forwarding considers stored entries only; the same-cycle incoming offer is not forwarded.
REQ-031 Duplicate destinations are permitted and are all written in order.
REQ-032 count never exceeds DEPTH and never underflows; hold has no effect on acceptance.

Reset
REQ-033 reset high at a rising edge: head = tail = 0, count = 0, all pending entries discarded.
REQ-034 During and after reset: inReady = 1, writeEnable = 0, writeAddr = 0, writeData = 0, fwdHit1/2 = 0, fwdData1/2 = 0.
REQ-035 reset asserted mid-operation takes priority over simultaneous accept/drain; no entry from that cycle survives.
REQ-036 Entry data storage is not required to be cleared by reset.

Verification
REQ-037 Empty, hold=0, offer {x5, 0x12345678} -> next cycle writeEnable=1, writeAddr=5, writeData=0x12345678; following cycle writeEnable=0, count=0.
REQ-038 hold=1, offer x1..x4 values 0x11..0x44 back-to-back -> count=4, inReady=0, fifth offer refused; release hold -> writes x1,x2,x3,x4 in four consecutive cycles.
REQ-039 hold=1, pending {x7,0xA},{x3,0xB},{x7,0xC}; fwdAddr1=7, fwdAddr2=3 -> fwdHit1=1 fwdData1=0xC, fwdHit2=1 fwdData2=0xB; fwdAddr1=0 -> fwdHit1=0.
REQ-040 Offer {x0, 0xDEAD} -> inReady=1, accepted, count stays 0, no writeEnable follows.
REQ-041 Full buffer, hold=0, inValid=1 held -> one drain per cycle, inReady=0 in first cycle, accept resumes next cycle, order preserved across pointer wrap.
REQ-042 Three entries pending, assert reset one cycle with inValid=1 -> count=0, writeEnable=0, fwdHit=0 next cycle; none of the entries ever written.

Source files
------------

// File: rtl/wb_buffer.sv
// Purpose : pending-write buffer between result producers and the register file, with operand forwarding.
// Latency : an entry accepted into an empty buffer drives writeEnable in the next cycle (hold low).
// Backpr. : inReady = (count < DEPTH); a full buffer refuses offers even when it drains in the same cycle.
//
// Ports:
//   clk, reset                     single clock, synchronous active-high reset
//   inValid/inReady/inAddr/inData  result offer handshake; inAddr == 0 completes the handshake but is dropped
//   hold                           stalls draining (never affects acceptance)
//   writeEnable/writeAddr/writeData head entry presented to the register file
//   fwdAddrN/fwdHitN/fwdDataN      youngest pending value for each decode read port
//   count                          number of valid entries
module wb_buffer #(
    parameter int DEPTH         = 4,
    parameter int WORD_LEN      = 32,
    parameter int REG_IDX_WIDTH = 5
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     inValid,
    output logic                     inReady,
    input  logic [REG_IDX_WIDTH-1:0] inAddr,
    input  logic [WORD_LEN-1:0]      inData,
    input  logic                     hold,
    output logic                     writeEnable,
    output logic [REG_IDX_WIDTH-1:0] writeAddr,
    output logic [WORD_LEN-1:0]      writeData,
    input  logic [REG_IDX_WIDTH-1:0] fwdAddr1,
    input  logic [REG_IDX_WIDTH-1:0] fwdAddr2,
    output logic                     fwdHit1,
    output logic                     fwdHit2,
    output logic [WORD_LEN-1:0]      fwdData1,
    output logic [WORD_LEN-1:0]      fwdData2,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [REG_IDX_WIDTH-1:0] entryAddr [DEPTH];
    logic [WORD_LEN-1:0]      entryData [DEPTH];
    logic [PTR_W-1:0]         head;
    logic [PTR_W-1:0]         tail;

    logic accept;
    logic enqueue;
    logic drain;

    // inReady looks only at the stored count, so a same-cycle drain never
    // opens a slot for a same-cycle offer.
    assign inReady     = (count < CNT_W'(DEPTH));
    assign accept      = inValid && inReady;
    // Writes to x0 are architecturally void: ack them but keep them out of the queue.
    assign enqueue     = accept && (inAddr != '0);
    assign writeEnable = (count != '0) && !hold;
    assign drain       = writeEnable;

    assign writeAddr = (count != '0) ? entryAddr[head] : '0;
    assign writeData = (count != '0) ? entryData[head] : '0;

    // Walk valid entries oldest to youngest; a later match overrides an
    // earlier one, leaving the youngest matching value on each port.
    always_comb begin
        logic [PTR_W-1:0] idx;
        idx      = '0;
        fwdHit1  = 1'b0;
        fwdHit2  = 1'b0;
        fwdData1 = '0;
        fwdData2 = '0;
        for (int i = 0; i < DEPTH; i++) begin
            idx = head + PTR_W'(i);
            if (CNT_W'(i) < count) begin
                if ((fwdAddr1 != '0) && (entryAddr[idx] == fwdAddr1)) begin
                    fwdHit1  = 1'b1;
                    fwdData1 = entryData[idx];
                end
                if ((fwdAddr2 != '0) && (entryAddr[idx] == fwdAddr2)) begin
                    fwdHit2  = 1'b1;
                    fwdData2 = entryData[idx];
                end
            end
        end
    end

    // Control state; reset wins over any same-cycle accept or drain.
    always_ff @(posedge clk) begin
        if (reset) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (enqueue) begin
                tail <= tail + PTR_W'(1);
            end
            if (drain) begin
                head <= head + PTR_W'(1);
            end
            case ({enqueue, drain})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Entry payload needs no reset: count == 0 makes stale contents invisible.
    always_ff @(posedge clk) begin
        if (enqueue) begin
            entryAddr[tail] <= inAddr;
            entryData[tail] <= inData;
        end
    end

endmodule
